stall_pipe_feeder: RTL and testbench

//  Upstream operand-issue stage for the stall pipeline. Accepts {a,b,c} operand

---
 rtl/stall_pipe_pkg.sv | 12 +
 rtl/stall_pipe_fifo.sv | 61 ++++++
 rtl/stall_pipe_feeder.sv | 69 ++++++
 tb/tb_stall_pipe_feeder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/stall_pipe_pkg.sv
// Shared operand types for the stall pipeline feeder and the pipeline stage.
package stall_pipe_pkg;

   localparam int OPW = 16;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      logic [OPW-1:0] c;
   } operand_t;

endpackage

// File: rtl/stall_pipe_fifo.sv
// Generic DEPTH x operand_t synchronous FIFO with a separate occupancy counter.
module stall_pipe_fifo
   import stall_pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  operand_t               din,
   output operand_t               head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   operand_t      r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign full   = (r_level == LW'(DEPTH));
   assign empty  = (r_level == '0);
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign head   = r_mem[r_rd_ptr];
   assign level  = r_level;

   // Storage is cleared too, so the head never exposes stale data after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/stall_pipe_feeder.sv
// Operand-issue stage: buffers {a,b,c} triples and presents the head with a stall
module stall_pipe_feeder
   import stall_pipe_pkg::*;
#(
   parameter int WIDTH = OPW,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_a,
   input  logic [WIDTH-1:0]       in_b,
   input  logic [WIDTH-1:0]       in_c,
   input  logic                   hold,
   output logic [WIDTH-1:0]       a,
   output logic [WIDTH-1:0]       b,
   output logic [WIDTH-1:0]       c,
   output logic                   stall,
   output logic [$clog2(DEPTH):0] level
);

   operand_t w_din;
   operand_t w_head;
   logic     w_push;
   logic     w_pop;
   logic     w_full;
   logic     w_empty;

   assign w_din.a  = in_a;
   assign w_din.b  = in_b;
   assign w_din.c  = in_c;

   assign in_ready = ~w_full;
   assign w_push   = in_valid & in_ready;
   assign stall    = w_empty | hold;
   assign w_pop    = ~stall;

   assign a = w_empty ? '0 : w_head.a;
   assign b = w_empty ? '0 : w_head.b;
   assign c = w_empty ? '0 : w_head.c;

   stall_pipe_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .head  (w_head),
      .level (level),
      .full  (w_full),
      .empty (w_empty)
   );

   // A held, non-empty head must not move; an empty-to-filled step is allowed.
   a_level_max : assert property (@(posedge clk) disable iff (!rst_n)
      level <= ($clog2(DEPTH)+1)'(DEPTH));
   a_no_ovf : assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && w_full));
   a_stall_empty : assert property (@(posedge clk) disable iff (!rst_n)
      stall || (level != '0));
   a_hold_stall : assert property (@(posedge clk) disable iff (!rst_n)
      hold |-> stall);
   a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (stall && level != '0) |=> $stable({a, b, c}));

endmodule

// File: tb/tb_stall_pipe_feeder.sv
// Directed table, corner sequences and a random queue-model run for the feeder.
module tb_stall_pipe_feeder;

   localparam int W = 16;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a, in_b, in_c;
   logic          hold;
   logic [W-1:0]  a, b, c;
   logic          stall;
   logic [2:0]    level;

   int checks = 0;
   int errors = 0;

   logic [47:0] q[$];

   typedef struct {
      logic        iv;
      logic [47:0] din;
      logic        h;
      logic [2:0]  lvl;
      logic        st;
      logic        rdy;
      logic [47:0] hd;
   } vec_t;

   vec_t tv[18];

   stall_pipe_feeder #(.WIDTH(W), .DEPTH(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_c     (in_c),
      .hold     (hold),
      .a        (a),
      .b        (b),
      .c        (c),
      .stall    (stall),
      .level    (level)
   );

   always #5 clk = ~clk;

   wire [52:0] w_obs = {level, stall, in_ready, a, b, c};

   function automatic logic [47:0] t3(input int x, input int y, input int z);
      return {16'(x), 16'(y), 16'(z)};
   endfunction

   function automatic vec_t mk(input logic iv, input logic [47:0] d,
                               input logic h, input int lvl,
                               input logic st, input logic rdy,
                               input logic [47:0] hd);
      vec_t v;
      v.iv = iv; v.din = d; v.h = h;
      v.lvl = 3'(lvl); v.st = st; v.rdy = rdy; v.hd = hd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [52:0] got,
                      input logic [52:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got lvl/st/rdy/abc=%h required %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [47:0] d, input logic h);
      in_valid = iv;
      {in_a, in_b, in_c} = d;
      hold = h;
   endtask

   // One cycle against the queue model: compare before the edge, then update.
   task automatic step(input logic iv, input logic [47:0] d, input logic h,
                       input string nm);
      logic [47:0] hd;
      logic        st, rd;
      @(negedge clk);
      drive(iv, d, h);
      #1;
      hd = (q.size() != 0) ? q[0] : 48'h0;
      st = (q.size() == 0) || h;
      rd = (q.size() != D);
      chk(nm, w_obs, {3'(q.size()), st, rd, hd});
      if (!st) void'(q.pop_front());
      if (iv && rd) q.push_back(d);
   endtask

   initial begin
      tv[0]  = mk(0, t3(0,0,0), 0, 0, 1, 1, t3(0,0,0));
      tv[1]  = mk(1, t3(1,2,3), 0, 0, 1, 1, t3(0,0,0));
      tv[2]  = mk(0, t3(0,0,0), 0, 1, 0, 1, t3(1,2,3));
      tv[3]  = mk(0, t3(0,0,0), 0, 0, 1, 1, t3(0,0,0));
      tv[4]  = mk(1, t3(0,1,2), 1, 0, 1, 1, t3(0,0,0));
      tv[5]  = mk(1, t3(1,2,3), 1, 1, 1, 1, t3(0,1,2));
      tv[6]  = mk(1, t3(2,3,4), 1, 2, 1, 1, t3(0,1,2));
      tv[7]  = mk(1, t3(3,4,5), 1, 3, 1, 1, t3(0,1,2));
      tv[8]  = mk(1, t3(9,9,9), 1, 4, 1, 0, t3(0,1,2));
      tv[9]  = mk(1, t3(9,9,9), 0, 4, 0, 0, t3(0,1,2));
      tv[10] = mk(0, t3(0,0,0), 0, 3, 0, 1, t3(1,2,3));
      tv[11] = mk(0, t3(0,0,0), 0, 2, 0, 1, t3(2,3,4));
      tv[12] = mk(0, t3(0,0,0), 0, 1, 0, 1, t3(3,4,5));
      tv[13] = mk(0, t3(0,0,0), 0, 0, 1, 1, t3(0,0,0));
      tv[14] = mk(1, t3(7,8,9), 1, 0, 1, 1, t3(0,0,0));
      tv[15] = mk(0, t3(0,0,0), 1, 1, 1, 1, t3(7,8,9));
      tv[16] = mk(0, t3(0,0,0), 0, 1, 0, 1, t3(7,8,9));
      tv[17] = mk(0, t3(0,0,0), 0, 0, 1, 1, t3(0,0,0));

      rst_n = 1'b0;
      drive(0, 48'h0, 0);
      #1;
      chk("reset_async", w_obs, {3'd0, 1'b1, 1'b1, 48'h0});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) step(0, 48'h0, 0, "idle");

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tv[i].iv, tv[i].din, tv[i].h);
         #1;
         chk($sformatf("vec%0d", i), w_obs,
             {tv[i].lvl, tv[i].st, tv[i].rdy, tv[i].hd});
      end

      step(1, t3(1,1,1), 1, "fill2_a");
      step(1, t3(2,2,2), 1, "fill2_b");
      for (int i = 0; i < 20; i++) begin
         step(1, t3(100+i, 200+i, 300+i), 0, "steady2");
         if (level !== 3'd2) begin
            checks++;
            errors++;
            $display("FAIL steady_level got %0d required 2", level);
         end
      end

      step(1, t3(50,51,52), 1, "to_lvl3");
      step(0, 48'h0, 1, "at_lvl3");
      drive(0, 48'h0, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midcycle_reset", w_obs, {3'd0, 1'b1, 1'b1, 48'h0});
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, t3(16'hA, 16'hB, 16'hC), 0, "post_rst_push");
      step(0, 48'h0, 0, "post_rst_head");
      step(0, 48'h0, 0, "post_rst_empty");

      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)), 48'($urandom) ^ (48'($urandom) << 16),
              ($urandom_range(0, 3) == 0), "random");
      end
      for (int i = 0; i < 6; i++) step(0, 48'h0, 0, "drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
